// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output serializer slice.
package fir_pkg;

    localparam int DATA_W = 16;

    localparam logic BYTE_HI = 1'b1;
    localparam logic BYTE_LO = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        HI_REQ,
        HI_REL,
        LO_REQ,
        LO_REL
    } oser_state_t;

    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] sample, input logic sel);
        return (sel == BYTE_HI) ? sample[15:8] : sample[7:0];
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock circular-buffer FIFO with show-ahead read data and an occupancy count.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_dat;
    end

    assign rd_dat = r_mem[r_rd_ptr];
    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;

endmodule

// File: rtl/fir_out_serializer.sv
// Ships buffered 16-bit FIR samples as MSB-first byte pairs over a 4-phase strobe/ack link.
// Define FIR_OSER_OVF_EN for drop mode (never stalls the FIR, counts lost samples).
module fir_out_serializer import fir_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] y_dat,
    input  logic              y_vld,
    output logic              y_rdy,
    output logic [7:0]        out_dat,
    output logic              out_stb,
    output logic              out_first,
    input  logic              out_ack,
    output logic              busy,
    output logic [7:0]        ovf_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              r_ack_meta;
    logic              r_ack_s;
    oser_state_t       r_state;
    oser_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_hold;
    logic [7:0]        r_out_dat;
    logic              r_out_stb;
    logic              r_out_first;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [PTR_W:0]    w_count;
    logic [DATA_W-1:0] w_rd_dat;
    logic              w_launch;
    logic              w_load_lo;
    logic              w_stb_clr;

    fir_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .wr_dat (y_dat),
        .pop    (w_launch),
        .rd_dat (w_rd_dat),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= out_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_load_lo   = 1'b0;
        w_stb_clr   = 1'b0;
        unique case (r_state)
            IDLE: if (!w_empty) begin
                w_launch    = 1'b1;
                w_state_nxt = HI_REQ;
            end
            HI_REQ: if (r_ack_s) begin
                w_stb_clr   = 1'b1;
                w_state_nxt = HI_REL;
            end
            HI_REL: if (!r_ack_s) begin
                w_load_lo   = 1'b1;
                w_state_nxt = LO_REQ;
            end
            LO_REQ: if (r_ack_s) begin
                w_stb_clr   = 1'b1;
                w_state_nxt = LO_REL;
            end
            LO_REL: if (!r_ack_s) begin
                if (!w_empty) begin
                    w_launch    = 1'b1;
                    w_state_nxt = HI_REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_out_dat   <= '0;
            r_out_stb   <= 1'b0;
            r_out_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_hold      <= w_rd_dat;
                r_out_dat   <= get_byte(w_rd_dat, BYTE_HI);
                r_out_first <= 1'b1;
                r_out_stb   <= 1'b1;
            end else if (w_load_lo) begin
                r_out_dat   <= get_byte(r_hold, BYTE_LO);
                r_out_first <= 1'b0;
                r_out_stb   <= 1'b1;
            end else if (w_stb_clr) begin
                r_out_stb   <= 1'b0;
            end
        end
    end

`ifdef FIR_OSER_OVF_EN
    logic [7:0] r_ovf_cnt;

    assign y_rdy = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (y_vld && w_full && !w_launch && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign y_rdy   = !w_full;
    assign ovf_cnt = '0;
`endif

    assign w_push    = y_vld && y_rdy;
    assign out_dat   = r_out_dat;
    assign out_stb   = r_out_stb;
    assign out_first = r_out_first;
    assign busy      = (w_count != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_fir_out_serializer.sv
// Self-checking bench: table-driven single samples, burst/backpressure, back-to-back, reset abort, async ack.
module tb_fir_out_serializer;
    import fir_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] y_dat;
    logic        y_vld;
    logic        y_rdy;
    logic [7:0]  out_dat;
    logic        out_stb;
    logic        out_first;
    logic        out_ack;
    logic        busy;
    logic [7:0]  ovf_cnt;
    logic        rd_ack  = 1'b0;
    logic        man_ack = 1'b0;

    assign out_ack = rd_ack | man_ack;

    fir_out_serializer #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .y_dat     (y_dat),
        .y_vld     (y_vld),
        .y_rdy     (y_rdy),
        .out_dat   (out_dat),
        .out_stb   (out_stb),
        .out_first (out_first),
        .out_ack   (out_ack),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       first;
        logic [7:0] dat;
    } byte_t;

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    byte_t sb[$];
    vec_t  tbl[6];
    int    n_checks   = 0;
    int    n_errors   = 0;
    int    bytes_seen = 0;
    bit    rd_en      = 1'b0;
    bit    rd_rand    = 1'b0;
    int    rd_dly     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reader model: takes each strobed byte against the scoreboard, then runs the 4-phase
    // handshake with ack edges 3 time units after the falling clock edge.
    initial begin : reader
        int    dly;
        int    n;
        byte_t exp_b;
        forever begin
            @(negedge clk);
            if (rd_en && out_stb && !out_ack) begin
                bytes_seen++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got byte 0x%0h first=%0b, want no byte", out_dat, out_first);
                end else begin
                    exp_b = sb.pop_front();
                    check("rx_byte", {out_first, out_dat}, {exp_b.first, exp_b.dat});
                end
                dly = rd_rand ? int'($urandom_range(0, 3)) : rd_dly;
                repeat (dly) @(negedge clk);
                #3 rd_ack = 1'b1;
                n = 0;
                while (out_stb && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("stb_release", (n < 100), 1);
                dly = rd_rand ? int'($urandom_range(0, 3)) : rd_dly;
                repeat (dly) @(negedge clk);
                #3 rd_ack = 1'b0;
            end
        end
    end

    oser_state_t prev_st = IDLE;
    logic        prev_first = 1'b0;
    int          b2b_cnt = 0;
    int          rel_idle_cnt = 0;
    int          first_rise = 0;

    always @(negedge clk) begin
        if (prev_st == LO_REL && dut.r_state == HI_REQ) b2b_cnt <= b2b_cnt + 1;
        if (prev_st == LO_REL && dut.r_state == IDLE)   rel_idle_cnt <= rel_idle_cnt + 1;
        if (out_first && !prev_first)                   first_rise <= first_rise + 1;
        prev_st    <= dut.r_state;
        prev_first <= out_first;
    end

    task automatic push_sample(input logic [15:0] d, input bit keep);
        int n = 0;
        while (!y_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_rdy_wait", (n < 2000), 1);
        if (keep) begin
            sb.push_back({1'b1, d[15:8]});
            sb.push_back({1'b0, d[7:0]});
        end
        y_dat = d;
        y_vld = 1'b1;
        @(negedge clk);
        y_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy || rd_ack) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, (n < 5000), 1);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running at time %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int bs0;
        int b2b0, idle0, fr0;

        tbl[0] = '{16'hA53C, 8'hA5, 8'h3C};
        tbl[1] = '{16'h0100, 8'h01, 8'h00};
        tbl[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        tbl[3] = '{16'h0000, 8'h00, 8'h00};
        tbl[4] = '{16'h5AC3, 8'h5A, 8'hC3};
        tbl[5] = '{16'h8001, 8'h80, 8'h01};

        y_vld = 1'b0;
        y_dat = '0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_dat", out_dat, 0);
        check("rst_out_stb", out_stb, 0);
        check("rst_out_first", out_first, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_y_rdy", y_rdy, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single samples, reader acking each strobe after 5 cycles.
        rd_en  = 1'b1;
        rd_dly = 5;
        for (int i = 0; i < 6; i++) begin
            sb.push_back({1'b1, tbl[i].hi});
            sb.push_back({1'b0, tbl[i].lo});
            push_sample(tbl[i].sample, 1'b0);
            wait_drain("single");
            check("single_idle", dut.r_state, IDLE);
        end

        // Burst: a lead sample parks the FSM in HI_REQ so the next DEPTH pushes fill the FIFO.
        rd_en = 1'b0;
        push_sample(16'h00FE, 1'b1);
        check("lat_edge_t", out_stb, 0);
        @(negedge clk);
        check("lat_edge_t1_stb", out_stb, 1);
        check("lat_edge_t1_first", out_first, 1);
        check("lat_edge_t1_dat", out_dat, 8'h00);
        for (int k = 0; k < DEPTH; k++) push_sample(16'h0100 + 16'(k), 1'b1);
`ifdef FIR_OSER_OVF_EN
        check("drop_y_rdy_tied", y_rdy, 1);
        push_sample(16'h0104, 1'b0);
        check("drop_ovf_one", ovf_cnt, 1);
        for (int k = 0; k < 300; k++) push_sample(16'h0200 + 16'(k), 1'b0);
        check("drop_ovf_sat", ovf_cnt, 255);
        rd_en = 1'b1;
`else
        check("bp_full_rdy", y_rdy, 0);
        bs0 = bytes_seen;
        fork
            push_sample(16'h0104, 1'b1);
            begin
                repeat (8) @(negedge clk);
                check("bp_stall_rdy", y_rdy, 0);
                rd_en = 1'b1;
            end
        join
        check("bp_rise_after_pop", ((bytes_seen - bs0) >= 2) && ((bytes_seen - bs0) <= 3), 1);
`endif
        wait_drain("burst");

        // Back-to-back: FSM holds one sample, FIFO one more, reader acks at once.
        rd_en  = 1'b0;
        rd_dly = 0;
        b2b0   = b2b_cnt;
        idle0  = rel_idle_cnt;
        fr0    = first_rise;
        push_sample(16'h1234, 1'b1);
        push_sample(16'h5678, 1'b1);
        rd_en = 1'b1;
        wait_drain("b2b");
        check("b2b_rel_to_hireq", b2b_cnt - b2b0, 1);
        check("b2b_rel_to_idle", rel_idle_cnt - idle0, 1);
        check("b2b_first_pulses", first_rise - fr0, 2);

        // Reset while the low byte of a sample is on the bus with 3 samples queued.
        rd_en = 1'b0;
        push_sample(16'hC0DE, 1'b0);
        push_sample(16'h1111, 1'b0);
        push_sample(16'h2222, 1'b0);
        push_sample(16'h3333, 1'b0);
        n = 0;
        while (!out_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_hi_stb", out_stb, 1);
        check("abort_hi_dat", {out_first, out_dat}, {1'b1, 8'hC0});
        #3 man_ack = 1'b1;
        @(negedge clk);
        check("ack_lat_edge1", out_stb, 1);
        @(negedge clk);
        check("ack_lat_edge2", out_stb, 1);
        @(negedge clk);
        check("ack_lat_edge3", out_stb, 0);
        #3 man_ack = 1'b0;
        n = 0;
        while (!out_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_lo_state", dut.r_state, LO_REQ);
        check("abort_lo_dat", {out_first, out_dat}, {1'b0, 8'hDE});
        rst = 1'b1;
        @(negedge clk);
        check("abort_stb", out_stb, 0);
        check("abort_busy", busy, 0);
        check("abort_fifo_empty", dut.u_fifo.empty, 1);
        check("abort_y_rdy", y_rdy, 1);
        rst = 1'b0;
        @(negedge clk);
        rd_en  = 1'b1;
        rd_dly = 2;
        push_sample(16'h00FF, 1'b1);
        wait_drain("post_rst");

        // Asynchronous ack with random reader pacing; pushes throttled so nothing can drop.
        rd_rand = 1'b1;
        bs0     = bytes_seen;
        for (int i = 0; i < 64; i++) begin
            n = 0;
            while (sb.size() > 2 * (DEPTH - 1) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            push_sample(16'($urandom), 1'b1);
        end
        wait_drain("async");
        check("async_byte_count", bytes_seen - bs0, 128);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
